// File: rtl/pcpu_uart_pkg.sv
// rtl/pcpu_uart_pkg.sv - shared UART state encoding and baud helper
package pcpu_uart_pkg;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_STOP      = 3'd3;
  localparam logic [2:0] S_WAIT_IDLE = 3'd4;

  typedef enum logic [2:0] {
    IDLE      = S_IDLE,
    START     = S_START,
    DATA      = S_DATA,
    STOP      = S_STOP,
    WAIT_IDLE = S_WAIT_IDLE
  } uart_state_e;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - show-ahead byte FIFO; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module uart_rx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [7:0]                 din,
  input  logic                       pop,
  output logic [7:0]                 dout,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/ch375_uart_rx.sv
// rtl/ch375_uart_rx.sv - 8N1 receiver for the CH375 TX line with mid-bit
// sampling, false-start rejection and a show-ahead FIFO with sticky flags.
module ch375_uart_rx #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 19200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  input  logic                          rd_en,
  output logic [7:0]                    dout,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          frame_err,
  output logic                          overrun,
  input  logic                          clr_err
);

  import pcpu_uart_pkg::*;

  localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
  localparam int CW  = $clog2(CPB);
  localparam logic [CW-1:0] CNT_BIT  = CW'(CPB - 1);
  // Start wait is counted from the cycle rx_s fell, one cycle before detection.
  localparam logic [CW-1:0] CNT_HALF = CW'(CPB / 2 - 2);

  if (CPB < 4) begin : g_chk_cpb
    $error("ch375_uart_rx: CLK_FREQ/BAUD must be at least 4");
  end
  if ((CLK_FREQ % BAUD) * 50 >= CLK_FREQ) begin : g_chk_baud
    $error("ch375_uart_rx: baud truncation error is 2%% or more");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
    $error("ch375_uart_rx: FIFO_DEPTH must be a power of two >= 2");
  end

  uart_state_e   state;
  logic          rx_m;
  logic          rx_s;
  logic          rx_s_d;
  logic [1:0]    warm;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          fifo_full;
  logic          stop_hit;
  logic          push;
  logic          set_fe;
  logic          set_ov;

  assign stop_hit = (state == STOP) && (cnt == '0);
  assign push     = stop_hit & rx_s & (~fifo_full | rd_en);
  assign set_ov   = stop_hit & rx_s & fifo_full & ~rd_en;
  assign set_fe   = stop_hit & ~rx_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rx_m      <= 1'b1;
      rx_s      <= 1'b1;
      rx_s_d    <= 1'b1;
      warm      <= '0;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      rx_m   <= rx;
      rx_s   <= rx_m;
      rx_s_d <= rx_s;
      // The preset synchronizer would fake a falling edge if rx is low at reset.
      if (warm != 2'd3) warm <= warm + 2'd1;

      frame_err <= set_fe | (frame_err & ~clr_err);
      overrun   <= set_ov | (overrun & ~clr_err);

      case (state)
        IDLE: begin
          if (warm == 2'd3 && rx_s_d && !rx_s) begin
            state <= START;
            cnt   <= CNT_HALF;
          end
        end
        START: begin
          if (cnt == '0) begin
            if (!rx_s) begin
              state   <= DATA;
              bit_idx <= '0;
              cnt     <= CNT_BIT;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DATA: begin
          if (cnt == '0) begin
            shreg <= {rx_s, shreg[7:1]};
            cnt   <= CNT_BIT;
            if (bit_idx == 3'd7) state <= STOP;
            else bit_idx <= bit_idx + 3'd1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        STOP: begin
          if (cnt == '0) state <= rx_s ? IDLE : WAIT_IDLE;
          else cnt <= cnt - CW'(1);
        end
        WAIT_IDLE: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (shreg),
    .pop   (rd_en),
    .dout  (dout),
    .empty (empty),
    .full  (fifo_full),
    .count (count)
  );

endmodule

// File: tb/tb_ch375_uart_rx.sv
// tb/tb_ch375_uart_rx.sv - directed bench for ch375_uart_rx
`timescale 1ns/1ps
module tb_ch375_uart_rx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic       rst_f = 1'b1, rx_f = 1'b1, rd_f = 1'b0, clr_f = 1'b0;
  logic [7:0] dout_f;
  logic       empty_f, fe_f, ov_f;
  logic [2:0] count_f;

  logic       rst_d = 1'b1, rx_d = 1'b1, rd_d = 1'b0, clr_d = 1'b0;
  logic [7:0] dout_d;
  logic       empty_d, fe_d, ov_d;
  logic [2:0] count_d;

  ch375_uart_rx #(.CLK_FREQ(1_000_000), .BAUD(100_000), .FIFO_DEPTH(4)) u_fast (
    .clk(clk), .rst(rst_f), .rx(rx_f), .rd_en(rd_f), .dout(dout_f), .empty(empty_f),
    .count(count_f), .frame_err(fe_f), .overrun(ov_f), .clr_err(clr_f)
  );

  ch375_uart_rx u_dflt (
    .clk(clk), .rst(rst_d), .rx(rx_d), .rd_en(rd_d), .dout(dout_d), .empty(empty_d),
    .count(count_d), .frame_err(fe_d), .overrun(ov_d), .clr_err(clr_d)
  );

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drive_f(input logic [9:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      rx_f = bits[i];
      tick(10);
    end
  endtask

  task automatic send_f(input logic [7:0] b);
    drive_f({1'b1, b, 1'b0}, 10);
  endtask

  task automatic pop_f();
    rd_f = 1'b1; tick(1); rd_f = 1'b0;
  endtask

  task automatic pulse_clr_f();
    clr_f = 1'b1; tick(1); clr_f = 1'b0;
  endtask

  task automatic test_reset();
    rst_f = 1'b1; rst_d = 1'b1; rx_f = 1'b1; rx_d = 1'b1;
    tick(3);
    total++; if (empty_f !== 1'b1) begin bad++; $display("FAIL reset_empty: got %b want 1", empty_f); end
    total++; if (count_f !== 3'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count_f); end
    total++; if (dout_f !== 8'h00) begin bad++; $display("FAIL reset_dout: got %h want 00", dout_f); end
    total++; if (fe_f !== 1'b0 || ov_f !== 1'b0) begin bad++; $display("FAIL reset_flags: got fe=%b ov=%b want 0 0", fe_f, ov_f); end
    total++; if (empty_d !== 1'b1 || count_d !== 3'd0 || dout_d !== 8'h00) begin bad++; $display("FAIL reset_dflt: got empty=%b count=%0d dout=%h want 1 0 00", empty_d, count_d, dout_d); end
    rst_f = 1'b0; rst_d = 1'b0;
    tick(5);
  endtask

  task automatic test_low_after_reset();
    rst_f = 1'b1; rx_f = 1'b0; tick(2);
    rst_f = 1'b0; tick(150);
    total++; if (empty_f !== 1'b1 || fe_f !== 1'b0) begin bad++; $display("FAIL low_after_reset: got empty=%b fe=%b want 1 0", empty_f, fe_f); end
    rx_f = 1'b1; tick(10);
  endtask

  task automatic test_latency();
    int n = 0;
    fork
      send_f(8'h55);
      begin
        while (n < 200 && empty_f) begin @(posedge clk); #1; n++; end
      end
    join
    total++; if (n < 96 || n > 98) begin bad++; $display("FAIL latency: got %0d cycles want 96..98", n); end
    total++; if (dout_f !== 8'h55) begin bad++; $display("FAIL latency_dout: got %h want 55", dout_f); end
    total++; if (count_f !== 3'd1) begin bad++; $display("FAIL latency_count: got %0d want 1", count_f); end
    total++; if (fe_f !== 1'b0 || ov_f !== 1'b0) begin bad++; $display("FAIL latency_flags: got fe=%b ov=%b want 0 0", fe_f, ov_f); end
    pop_f();
    total++; if (empty_f !== 1'b1) begin bad++; $display("FAIL latency_pop: got empty=%b want 1", empty_f); end
    pop_f();
    total++; if (empty_f !== 1'b1 || count_f !== 3'd0) begin bad++; $display("FAIL pop_empty_noop: got empty=%b count=%0d want 1 0", empty_f, count_f); end
  endtask

  task automatic test_false_start();
    rx_f = 1'b0; tick(3);
    rx_f = 1'b1; tick(40);
    total++; if (empty_f !== 1'b1 || fe_f !== 1'b0 || ov_f !== 1'b0) begin bad++; $display("FAIL false_start: got empty=%b fe=%b ov=%b want 1 0 0", empty_f, fe_f, ov_f); end
    send_f(8'h3C); tick(2);
    total++; if (dout_f !== 8'h3C || count_f !== 3'd1) begin bad++; $display("FAIL false_start_next: got dout=%h count=%0d want 3c 1", dout_f, count_f); end
    pop_f();
  endtask

  task automatic test_frame_err();
    drive_f({1'b0, 8'hA3, 1'b0}, 10);
    tick(30);
    rx_f = 1'b1; tick(20);
    total++; if (fe_f !== 1'b1 || empty_f !== 1'b1) begin bad++; $display("FAIL frame_err_set: got fe=%b empty=%b want 1 1", fe_f, empty_f); end
    send_f(8'h01); tick(5);
    total++; if (count_f !== 3'd1 || dout_f !== 8'h01) begin bad++; $display("FAIL frame_err_next: got count=%0d dout=%h want 1 01", count_f, dout_f); end
    pop_f();
    total++; if (empty_f !== 1'b1) begin bad++; $display("FAIL frame_err_pop: got empty=%b want 1", empty_f); end
    pulse_clr_f();
    total++; if (fe_f !== 1'b0) begin bad++; $display("FAIL frame_err_clr: got %b want 0", fe_f); end
  endtask

  task automatic test_overrun();
    for (int b = 8'h10; b <= 8'h14; b++) send_f(8'(b));
    tick(5);
    total++; if (count_f !== 3'd4) begin bad++; $display("FAIL overrun_count: got %0d want 4", count_f); end
    total++; if (dout_f !== 8'h10) begin bad++; $display("FAIL overrun_head: got %h want 10", dout_f); end
    total++; if (ov_f !== 1'b1 || fe_f !== 1'b0) begin bad++; $display("FAIL overrun_flag: got ov=%b fe=%b want 1 0", ov_f, fe_f); end
    for (int i = 0; i < 4; i++) begin
      total++; if (dout_f !== 8'(8'h10 + i)) begin bad++; $display("FAIL overrun_pop%0d: got %h want %h", i, dout_f, 8'(8'h10 + i)); end
      pop_f();
    end
    total++; if (empty_f !== 1'b1) begin bad++; $display("FAIL overrun_drained: got empty=%b want 1", empty_f); end
    pulse_clr_f();
    total++; if (ov_f !== 1'b0) begin bad++; $display("FAIL overrun_clr: got %b want 0", ov_f); end
  endtask

  task automatic test_simul_push_pop();
    for (int b = 8'h30; b <= 8'h33; b++) send_f(8'(b));
    tick(2);
    total++; if (count_f !== 3'd4 || ov_f !== 1'b0) begin bad++; $display("FAIL simul_fill: got count=%0d ov=%b want 4 0", count_f, ov_f); end
    fork
      send_f(8'h22);
      begin tick(96); rd_f = 1'b1; tick(1); rd_f = 1'b0; end
    join
    total++; if (ov_f !== 1'b0) begin bad++; $display("FAIL simul_overrun: got %b want 0", ov_f); end
    total++; if (count_f !== 3'd4) begin bad++; $display("FAIL simul_count: got %0d want 4", count_f); end
    for (int i = 0; i < 4; i++) begin
      logic [7:0] exp;
      exp = (i == 3) ? 8'h22 : 8'(8'h31 + i);
      total++; if (dout_f !== exp) begin bad++; $display("FAIL simul_pop%0d: got %h want %h", i, dout_f, exp); end
      pop_f();
    end
    total++; if (empty_f !== 1'b1) begin bad++; $display("FAIL simul_drained: got empty=%b want 1", empty_f); end
  endtask

  task automatic test_set_wins();
    for (int b = 8'h40; b <= 8'h43; b++) send_f(8'(b));
    fork
      send_f(8'h77);
      begin tick(96); clr_f = 1'b1; tick(1); clr_f = 1'b0; end
    join
    total++; if (ov_f !== 1'b1 || count_f !== 3'd4) begin bad++; $display("FAIL set_wins: got ov=%b count=%0d want 1 4", ov_f, count_f); end
    pulse_clr_f();
    total++; if (ov_f !== 1'b0) begin bad++; $display("FAIL set_wins_clr: got %b want 0", ov_f); end
    repeat (4) pop_f();
    total++; if (empty_f !== 1'b1) begin bad++; $display("FAIL set_wins_drained: got empty=%b want 1", empty_f); end
  endtask

  task automatic test_reset_midframe();
    send_f(8'h99);
    drive_f({1'b1, 8'h5A, 1'b0}, 5);
    rx_f = 1'b1;
    tick(4);
    #3 rst_f = 1'b1;
    #1;
    total++; if (empty_f !== 1'b1 || count_f !== 3'd0 || dout_f !== 8'h00) begin bad++; $display("FAIL async_reset: got empty=%b count=%0d dout=%h want 1 0 00", empty_f, count_f, dout_f); end
    tick(3);
    rst_f = 1'b0;
    tick(10);
    send_f(8'hC6); tick(2);
    total++; if (dout_f !== 8'hC6 || count_f !== 3'd1 || fe_f !== 1'b0 || ov_f !== 1'b0) begin bad++; $display("FAIL after_reset_frame: got dout=%h count=%0d fe=%b ov=%b want c6 1 0 0", dout_f, count_f, fe_f, ov_f); end
    pop_f();
  endtask

  task automatic test_default_baud();
    logic [9:0] bits;
    bits = {1'b1, 8'h55, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_d = bits[i];
      #52083;
    end
    total++; if (empty_d !== 1'b0 || count_d !== 3'd1) begin bad++; $display("FAIL dflt_count: got empty=%b count=%0d want 0 1", empty_d, count_d); end
    total++; if (dout_d !== 8'h55) begin bad++; $display("FAIL dflt_dout: got %h want 55", dout_d); end
    total++; if (fe_d !== 1'b0 || ov_d !== 1'b0) begin bad++; $display("FAIL dflt_flags: got fe=%b ov=%b want 0 0", fe_d, ov_d); end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_low_after_reset();
    test_latency();
    test_false_start();
    test_frame_err();
    test_overrun();
    test_simul_push_pop();
    test_set_wins();
    test_reset_midframe();
    test_default_baud();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ch375_uart_rx.md
Name: ch375_uart_rx

Overview:
- Serial receiver for the CH375 USB host chip's TX line (`ch375_tx` at the top level), feeding bytes to the CPU-side CH375 MMIO peripheral inside pcpu_main.
- 8N1 UART, fixed baud set by a clock divider, with mid-bit sampling and false-start rejection.
- Includes a small show-ahead FIFO with sticky framing-error and overrun flags so software polling can tolerate latency.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD, 19200, line rate in bit/s. CLKS_PER_BIT = CLK_FREQ/BAUD, truncated (5208 at defaults).
- FIFO_DEPTH, 4, byte entries; must be a power of two, ≥2.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, reset. Asynchronous, active-high.
- rx, in, 1, raw serial input from CH375. Idles high. Asynchronous to clk.
- rd_en, in, 1, pop the head byte; ignored when empty.
- dout, out, 8, head byte of the FIFO (show-ahead); valid when !empty.
- empty, out, 1, FIFO holds no bytes.
- count, out, $clog2(FIFO_DEPTH)+1, number of bytes held.
- frame_err, out, 1, sticky: a stop bit was sampled low.
- overrun, out, 1, sticky: a byte arrived while the FIFO was full.
- clr_err, in, 1, one-cycle pulse; clears frame_err and overrun.

Behaviour:
- Reset values (asynchronous):
  - FSM = IDLE, all counters 0, FIFO pointers 0.
  - empty=1, count=0, dout=0, frame_err=0, overrun=0.
  - rx synchronizer flops preset to 1.
- rx passes through a 2-FF synchronizer (rx_s). All decisions use rx_s; input-to-decision latency is 2 clk.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE:
  - A 1→0 transition on rx_s loads the bit counter and goes to START.
  - rx_s held low out of reset, or after WAIT_IDLE, does not start a frame; a falling edge is required.
- START:
  - Wait CLKS_PER_BIT/2 cycles, then sample rx_s.
  - Low → DATA, bit index 0, counter reloaded.
  - High → false start, back to IDLE; no flags change.
- DATA:
  - Every CLKS_PER_BIT cycles, sample rx_s into the shift register, LSB first.
  - After bit 7 → STOP.
- STOP: after CLKS_PER_BIT cycles, sample rx_s.
  - High, FIFO not full → push the byte; go to IDLE.
  - High, FIFO full, rd_en=0 → drop the byte, set overrun; go to IDLE.
  - High, FIFO full, rd_en=1 in the same cycle → pop and push both occur, count unchanged, no overrun.
  - Low → drop the byte, set frame_err, go to WAIT_IDLE.
- WAIT_IDLE: stays until rx_s=1, then IDLE. This handles line breaks; no bytes are produced meanwhile.
- Push timing: the byte is visible on dout and empty falls on the cycle after the stop-bit sample. Worst-case rx→byte latency ≈ 2 + 9.5·CLKS_PER_BIT cycles.
- FIFO:
  - Pop on rd_en & !empty. The next head appears on dout the following cycle.
  - rd_en while empty is a no-op.
  - Pointers wrap modulo FIFO_DEPTH.
  - count is exact, range 0..FIFO_DEPTH.
- Flags: clr_err in the same cycle as a new error event leaves the flag set (set wins).
- Counter widths are sized from CLKS_PER_BIT. There is no fractional-baud accumulation; truncation error must stay under 2% (checked at elaboration by an assertion in simulation).

Decomposition:
- Shared package pcpu_uart_pkg holds:
  - FSM state encoding (3-bit localparams).
  - Helper function clks_per_bit(CLK_FREQ, BAUD).
  - Reused by a future ch375_uart_tx.
- One sub-module: uart_rx_fifo.
  - Parameterized depth, width 8.
  - Show-ahead output; push/pop/count/full/empty.
  - Async active-high reset.

Test Plan (CLK_FREQ=1_000_000, BAUD=100_000 → CLKS_PER_BIT=10 unless noted):
- Send 0x55 8N1 → empty falls 2+95 ±1 cycles after the start edge; dout=0x55; count=1; no flags set.
- Pulse rx low for 3 cycles, then high → FSM returns to IDLE; empty stays 1; frame_err=0.
- Send 0xA3 with stop bit low, hold rx low 30 cycles, then high, then send 0x01 → frame_err=1; only 0x01 is in the FIFO. Pulse clr_err → frame_err=0.
- Send 0x10..0x14 with no reads → count=4; dout=0x10; overrun=1. Pop four times → 0x10,0x11,0x12,0x13; then empty=1.
- FIFO full; assert rd_en exactly on the stop-sample cycle of 0x22 → overrun=0; count stays 4; 0x22 is the last byte out.
- Defaults (100 MHz, 19200 baud): drive 52083 ns bits for 0x55 → dout=0x55, no errors. Assert rst mid-frame at bit 4 → all outputs return to reset values asynchronously, and the next full frame is received correctly.
